// File: rtl/soc2_ram_arbiter.sv
// Two-port Avalon-MM round-robin arbiter in front of a single-cycle-latency RAM.
// Commands addressed at or beyond DEPTH are accepted and then dropped, and reads to them return zero.
module soc2_ram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 5120
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata,

    output logic                oor_err
);

    localparam int BE_W = DATA_W / 8;

    logic                last_grant;
    logic                req0, req1;
    logic                gnt0, gnt1, gnt_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [BE_W-1:0]     sel_be;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;
    logic                sel_oor;

    logic                rd_valid;
    logic                rd_owner;
    logic                rd_oor;
    logic [DATA_W-1:0]   rd_data;

    always_comb begin
        req0    = m0_read | m0_write;
        req1    = m1_read | m1_write;
        gnt0    = req0 & (~req1 | last_grant);
        gnt1    = req1 & (~req0 | ~last_grant);
        gnt_any = gnt0 | gnt1;

        if (gnt1) begin
            sel_addr  = m1_address;
            sel_be    = m1_byteenable;
            sel_wdata = m1_writedata;
            sel_write = m1_write;
        end else begin
            sel_addr  = m0_address;
            sel_be    = m0_byteenable;
            sel_wdata = m0_writedata;
            sel_write = m0_write;
        end

        // Compared at 64 bits so a DEPTH beyond the address range never truncates.
        sel_oor = gnt_any && ({{(64-ADDR_W){1'b0}}, sel_addr} >= 64'(DEPTH));
    end

    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    assign ram_address    = sel_addr;
    assign ram_byteenable = sel_be;
    assign ram_writedata  = sel_wdata;
    assign ram_chipselect = gnt_any & ~sel_oor & ~reset;
    assign ram_write      = gnt_any & ~sel_oor & sel_write & ~reset;
    assign ram_clken      = ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            rd_valid   <= 1'b0;
            rd_owner   <= 1'b0;
            rd_oor     <= 1'b0;
            oor_err    <= 1'b0;
        end else begin
            if (gnt_any)
                last_grant <= gnt1;
            rd_valid <= gnt_any & ~sel_write;
            rd_owner <= gnt1;
            rd_oor   <= sel_oor;
            oor_err  <= sel_oor;
        end
    end

    // Both ports see the same return data; readdatavalid alone tells the owner.
    assign rd_data          = rd_oor ? '0 : ram_readdata;
    assign m0_readdata      = rd_data;
    assign m1_readdata      = rd_data;
    assign m0_readdatavalid = rd_valid & ~rd_owner;
    assign m1_readdatavalid = rd_valid & rd_owner;

endmodule

// File: tb/tb_soc2_ram_arbiter.sv
// Bench for soc2_ram_arbiter: vector table for grants/strobes, scoreboard queue for read returns,
// plus hand-written reset-in-flight and first-contention sequences.
module tb_soc2_ram_arbiter;

    logic        clk;
    logic        reset;
    logic [12:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [12:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_readdata;
    logic        oor_err;

    soc2_ram_arbiter #(.ADDR_W(13), .DATA_W(32), .DEPTH(5120)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
        .oor_err(oor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initpat(input int a);
        return 32'h5EED_0000 | 32'(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    // Environment RAM: one-cycle read latency, byte-enabled writes.
    logic        fill;
    logic [31:0] ram_mem [0:8191];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 8192; i++) ram_mem[i] <= initpat(i);
        end else if (ram_clken && ram_chipselect) begin
            if (ram_write)
                ram_mem[ram_address] <= merge(ram_mem[ram_address], ram_writedata, ram_byteenable);
            else
                ram_readdata <= ram_mem[ram_address];
        end
    end

    typedef struct {
        logic r0, w0; logic [12:0] a0; logic [3:0] be0; logic [31:0] d0;
        logic r1, w1; logic [12:0] a1; logic [3:0] be1; logic [31:0] d1;
        logic ew0, ew1, ecs, ewe; logic [12:0] eaddr;
    } vec_t;

    typedef struct {
        logic v; logic own; logic oor; logic [31:0] data;
    } sb_t;

    logic [31:0] gold [0:8191];
    sb_t         sb [$];
    vec_t        vecs [$];
    int          total, passed, cur;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL step%0d %s: got %h expected %h", cur, nm, act, exp);
    endtask

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [12:0] a0, input logic [3:0] be0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [12:0] a1, input logic [3:0] be1, input logic [31:0] d1,
        input logic ew0, input logic ew1, input logic ecs, input logic ewe, input logic [12:0] eaddr);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.be0 = be0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.ew0 = ew0; v.ew1 = ew1; v.ecs = ecs; v.ewe = ewe; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_byteenable = v.be0; m0_writedata = v.d0;
        m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_byteenable = v.be1; m1_writedata = v.d1;
    endtask

    task automatic sb_check();
        sb_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("m0_readdatavalid", 64'(m0_readdatavalid), 64'(e.v && !e.own));
            check("m1_readdatavalid", 64'(m1_readdatavalid), 64'(e.v && e.own));
            check("oor_err", 64'(oor_err), 64'(e.oor));
            if (e.v)
                check("readdata", 64'(e.own ? m1_readdata : m0_readdata), 64'(e.data));
        end
    endtask

    task automatic apply(input vec_t v);
        logic g0, g1, gw, oor;
        logic [12:0] ga;
        logic [3:0]  gbe;
        logic [31:0] gd;
        sb_t e;
        sb_check();
        drive(v);
        #1;
        check("m0_waitrequest", 64'(m0_waitrequest), 64'(v.ew0));
        check("m1_waitrequest", 64'(m1_waitrequest), 64'(v.ew1));
        check("ram_chipselect", 64'(ram_chipselect), 64'(v.ecs));
        check("ram_write", 64'(ram_write), 64'(v.ewe));
        if (v.ecs) check("ram_address", 64'(ram_address), 64'(v.eaddr));
        g0  = (v.r0 | v.w0) & !v.ew0;
        g1  = (v.r1 | v.w1) & !v.ew1;
        ga  = g1 ? v.a1 : v.a0;
        gw  = g1 ? v.w1 : v.w0;
        gbe = g1 ? v.be1 : v.be0;
        gd  = g1 ? v.d1 : v.d0;
        if (v.ewe) begin
            check("ram_writedata", 64'(ram_writedata), 64'(gd));
            check("ram_byteenable", 64'(ram_byteenable), 64'(gbe));
        end
        oor    = (ga >= 13'd5120);
        e.v    = (g0 | g1) & !gw;
        e.own  = g1;
        e.oor  = (g0 | g1) & oor;
        e.data = oor ? 32'h0 : gold[ga];
        if ((g0 | g1) && gw && !oor) gold[ga] = merge(gold[ga], gd, gbe);
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        total = 0; passed = 0; cur = 0;
        for (int i = 0; i < 8192; i++) gold[i] = initpat(i);
        drive(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));
        reset = 1'b1; fill = 1'b1;
        repeat (2) @(posedge clk);
        fill = 1'b0;
        @(negedge clk);
        m0_read = 1'b1; m0_address = 13'h010;
        #1;
        check("reset ram_clken", 64'(ram_clken), 64'd0);
        check("reset ram_chipselect", 64'(ram_chipselect), 64'd0);
        check("reset ram_write", 64'(ram_write), 64'd0);
        check("reset m0_readdatavalid", 64'(m0_readdatavalid), 64'd0);
        check("reset m1_readdatavalid", 64'(m1_readdatavalid), 64'd0);
        check("reset oor_err", 64'(oor_err), 64'd0);
        m0_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ram_clken after release", 64'(ram_clken), 64'd1);

        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(1,0,13'h011,4'hF,0, 1,0,13'h041,4'hF,0, 0,1,1,0,13'h011));
            vecs.push_back(mk(1,0,13'h011,4'hF,0, 1,0,13'h041,4'hF,0, 1,0,1,0,13'h041));
        end
        vecs.push_back(mk(1,0,13'h010,4'hF,0, 0,0,0,0,0, 0,0,1,0,13'h010));
        vecs.push_back(mk(0,0,0,0,0, 0,1,13'h100,4'h3,32'hA5A5_5A5A, 0,0,1,1,13'h100));
        vecs.push_back(mk(1,0,13'h100,4'hF,0, 0,0,0,0,0, 0,0,1,0,13'h100));
        vecs.push_back(mk(1,0,13'h1400,4'hF,0, 0,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,1,13'h020,4'hF,32'h1234_5678, 0,0,0,0,0, 0,0,1,1,13'h020));
        vecs.push_back(mk(1,0,13'h020,4'hF,0, 0,0,0,0,0, 0,0,1,0,13'h020));
        vecs.push_back(mk(0,0,0,0,0, 1,0,13'h1FFF,4'hF,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,1,13'h13FF,4'hC,32'hDEAD_BEEF, 0,0,1,1,13'h13FF));
        vecs.push_back(mk(0,0,0,0,0, 1,0,13'h13FF,4'hF,0, 0,0,1,0,13'h13FF));
        vecs.push_back(mk(0,1,13'h200,4'hF,32'h1111_2222, 0,1,13'h201,4'hF,32'h3333_4444, 0,1,1,1,13'h200));
        vecs.push_back(mk(0,1,13'h200,4'hF,32'h1111_2222, 0,1,13'h201,4'hF,32'h3333_4444, 1,0,1,1,13'h201));
        vecs.push_back(mk(0,1,13'h1400,4'hF,32'hFFFF_FFFF, 0,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0,13'h200,4'hF,0, 1,0,13'h201,4'hF,0, 1,0,1,0,13'h201));
        vecs.push_back(mk(1,0,13'h200,4'hF,0, 1,0,13'h201,4'hF,0, 0,1,1,0,13'h200));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            cur = i + 1;
            apply(vecs[i]);
        end
        cur = 100;
        sb_check();

        // Read in flight when reset hits: its return must never appear.
        cur = 200;
        drive(mk(0,0,0,0,0, 1,0,13'h050,4'hF,0, 0,0,0,0,0));
        #1;
        check("inflight m1_waitrequest", 64'(m1_waitrequest), 64'd0);
        check("inflight ram_chipselect", 64'(ram_chipselect), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));
        #1;
        check("pulse m1_readdatavalid", 64'(m1_readdatavalid), 64'd0);
        check("pulse ram_clken", 64'(ram_clken), 64'd0);
        check("pulse oor_err", 64'(oor_err), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post-reset m0_readdatavalid", 64'(m0_readdatavalid), 64'd0);
            check("post-reset m1_readdatavalid", 64'(m1_readdatavalid), 64'd0);
        end

        cur = 300;
        drive(mk(1,0,13'h060,4'hF,0, 1,0,13'h061,4'hF,0, 0,0,0,0,0));
        #1;
        check("first contention m0_waitrequest", 64'(m0_waitrequest), 64'd0);
        check("first contention m1_waitrequest", 64'(m1_waitrequest), 64'd1);
        check("first contention ram_address", 64'(ram_address), 64'h060);
        @(negedge clk);
        drive(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));
        check("first contention m0_readdatavalid", 64'(m0_readdatavalid), 64'd1);
        check("first contention m1_readdatavalid", 64'(m1_readdatavalid), 64'd0);
        check("first contention readdata", 64'(m0_readdata), 64'(gold[13'h060]));
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/soc2_ram_arbiter.md
SOC2_RAM_ARBITER -- requirements
Module: soc2_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, word-address width of both requester ports and the RAM port.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width SHALL be DATA_W/8.
REQ-003 Parameter DEPTH, default 5120, number of implemented RAM words.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mN_address / mN_byteenable / mN_read / mN_write / mN_writedata  in  ADDR_W / DATA_W/8 / 1 / 1 / DATA_W  requester N (N=0,1) Avalon-MM command.
REQ-007 mN_waitrequest  out  1  command of requester N not accepted this cycle.
REQ-008 mN_readdata / mN_readdatavalid  out  DATA_W / 1  read return to requester N.
REQ-009 ram_address / ram_byteenable / ram_writedata  out  ADDR_W / DATA_W/8 / DATA_W  shared RAM command.
REQ-010 ram_chipselect / ram_write / ram_clken  out  1 / 1 / 1  RAM strobes.
REQ-011 ram_readdata  in  DATA_W  RAM output, valid one cycle after a read command is presented.
REQ-012 oor_err  out  1  one-cycle pulse: accepted command addressed >= DEPTH.

Function
- Request: mN_req = mN_read | mN_write; read and write both high is treated as a write.
REQ-013 At most one requester SHALL be granted per cycle; grant is combinational from current requests and the last_grant register.
REQ-014 One request only: that requester SHALL be granted.
REQ-015 Both requesting: the requester not equal to last_grant SHALL be granted (round-robin).
REQ-016 last_grant SHALL update to the granted index on every cycle with a grant and hold otherwise.
REQ-017 mN_waitrequest SHALL be 0 exactly when N is granted or mN_req=0; a requesting, ungranted port sees 1.
REQ-018 Granted in-range command: ram_chipselect=1, ram_write=granted write, address/byteenable/writedata muxed from the granted port, same cycle.
REQ-019 No grant: ram_chipselect=0, ram_write=0; other ram_* outputs are don't-care.
REQ-020 ram_clken SHALL be 1 whenever reset is deasserted.
REQ-021 Accepted read SHALL load a pipeline register {rd_valid=1, rd_owner=N, rd_oor}; otherwise rd_valid=0 next cycle.
REQ-022 Cycle after an accepted read: mN_readdatavalid=1 for rd_owner only, mN_readdata=ram_readdata (or all-zeros if rd_oor); fixed read latency is 1 cycle.
REQ-023 Back-to-back reads (either port, alternating or same) SHALL be accepted every cycle with no bubble.
REQ-024 Write acceptance SHALL produce no readdatavalid.
REQ-025 Address >= DEPTH: command accepted (waitrequest 0), ram_chipselect=0, oor_err=1 next cycle; a read returns zero with readdatavalid; a write is dropped.
REQ-026 mN_readdata SHALL drive ram_readdata-derived data to both ports; only readdatavalid qualifies it.

Reset
REQ-027 While reset=1: last_grant=1 (so port 0 wins first contention), rd_valid=0, all readdatavalid=0, oor_err=0, ram_chipselect=0, ram_write=0, ram_clken=0.
REQ-028 Reset asserted with a read in flight: the pending readdatavalid SHALL be suppressed; no return after reset release.
REQ-029 First cycle after release: normal arbitration, no residual state.

Verification
REQ-030 m0 read addr 0x010 alone -> m0_waitrequest=0 same cycle, ram_address=0x010, m0_readdatavalid=1 next cycle with RAM word; m1 signals idle.
REQ-031 m0 and m1 both read continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; each waitrequest low on alternate cycles; readdatavalid owners follow one cycle later.
REQ-032 m1 write 0xA5A5_5A5A addr 0x100 byteenable 0b0011, then m0 read 0x100 -> RAM write strobe with byteenable 0011; read returns low half 0x5A5A with prior upper half unchanged.
REQ-033 m0 read addr 5120 (0x1400) -> waitrequest 0, ram_chipselect 0, next cycle m0_readdatavalid=1, m0_readdata=0, oor_err=1 for one cycle.
REQ-034 m1 read accepted, reset pulsed next edge for 1 cycle -> m1_readdatavalid never asserts; after release m0 and m1 contending -> m0 granted first.
REQ-035 m0 write and read both high addr 0x020 -> treated as write, no readdatavalid.
